// File: rtl/rtc_host.sv
// rtc_host: serial initiator for the 3-wire PRAM/RTC bus.
//
// Turns one parallel request into a complete chip-select framed transaction:
// a standard command (command byte + data byte) or an extended XPRAM command
// (two command bytes + data byte). Bits travel MSB first. Every bus phase
// (SETUP, each LOW and HIGH half of a bit, HOLD, GAP) lasts CLK_DIV cycles.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          request strobe, taken only when idle (including the done cycle)
//   xcmd           1 = extended transaction (cmd0, cmd1, data), 0 = standard
//   cmd0, cmd1     command bytes; cmd0[7] = 1 selects a read
//   wdata          data byte sent on writes
//   busy           transaction in progress
//   done           one-cycle pulse when the transaction ends
//   rdata          byte returned by the last read, held until the next read
//   rtc_cs_n       chip select, active low
//   rtc_ck         serial clock, idles high
//   rtc_dat_o      serial data towards the responder
//   rtc_dat_oe     1 = host drives the data line
//   rtc_dat_i      serial data from the responder (synchronous to clk)

module rtc_host #(
    parameter int CLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       xcmd,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rtc_cs_n,
    output logic       rtc_ck,
    output logic       rtc_dat_o,
    output logic       rtc_dat_oe,
    input  logic       rtc_dat_i
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        xcmd_q, xcmd_d;
    logic        rd_q, rd_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        cs_n_q, cs_n_d;
    logic        ck_q, ck_d;
    logic        dat_o_q, dat_o_d;
    logic        dat_oe_q, dat_oe_d;

    logic        cnt_last;
    logic [4:0]  last_bit;
    logic        in_data_q;
    logic        phase_d;
    logic        rd_data_d;

    // Sequencing: a phase counter paces every state, a bit counter walks the
    // 8N bits, and the transmit word is shifted left once per bit so that its
    // MSB is always the bit currently on the wire.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        xcmd_d   = xcmd_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;

        cnt_last  = (cnt_q == DIV_LAST);
        last_bit  = xcmd_q ? 5'd23 : 5'd15;
        in_data_q = (bit_q >= (xcmd_q ? 5'd16 : 5'd8));

        if (state_q != S_IDLE) begin
            cnt_d = cnt_last ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    cnt_d   = 8'd0;
                    bit_d   = 5'd0;
                    xcmd_d  = xcmd;
                    rd_d    = cmd0[7];
                    rx_d    = 8'h00;
                    // Standard transactions use only the top 16 bits.
                    tx_d    = xcmd ? {cmd0, cmd1, wdata} : {cmd0, wdata, 8'h00};
                end
            end
            S_SETUP: begin
                if (cnt_last) state_d = S_LOW;
            end
            S_LOW: begin
                if (cnt_last) begin
                    state_d = S_HIGH;
                    // Sample just before the rising edge the responder drives against.
                    if (rd_q && in_data_q) rx_d = {rx_q[6:0], rtc_dat_i};
                end
            end
            S_HIGH: begin
                if (cnt_last) begin
                    if (bit_q == last_bit) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_q + 5'd1;
                        tx_d    = {tx_q[22:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (cnt_last) state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (rd_q) rdata_d = rx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus pins are decoded from the next state so they leave flops directly.
    always_comb begin
        phase_d   = (state_d == S_LOW) || (state_d == S_HIGH);
        rd_data_d = rd_d && (bit_d >= (xcmd_d ? 5'd16 : 5'd8));
        busy_d    = (state_d != S_IDLE);
        cs_n_d    = (state_d == S_IDLE) || (state_d == S_GAP);
        ck_d      = (state_d != S_LOW);
        dat_oe_d  = phase_d && !rd_data_d;
        dat_o_d   = 1'b1;
        if (phase_d && !rd_data_d) dat_o_d = tx_d[23];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            bit_q    <= 5'd0;
            tx_q     <= 24'h000000;
            rx_q     <= 8'h00;
            xcmd_q   <= 1'b0;
            rd_q     <= 1'b0;
            rdata_q  <= 8'h00;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ck_q     <= 1'b1;
            dat_o_q  <= 1'b1;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            xcmd_q   <= xcmd_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cs_n_q   <= cs_n_d;
            ck_q     <= ck_d;
            dat_o_q  <= dat_o_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign rtc_cs_n   = cs_n_q;
    assign rtc_ck     = ck_q;
    assign rtc_dat_o  = dat_o_q;
    assign rtc_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_rtc_host.sv
// tb_rtc_host: self-checking bench for rtc_host.
//
// A behavioural responder watches the bus, collects the bits seen on rising
// rtc_ck edges together with the drive enable, counts falling edges and, on
// reads, returns a byte chosen by the test. Expected values come from the
// transaction contents and the documented cycle formulas.

module tb_rtc_host;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start16;
    logic       xcmd;
    logic [7:0] cmd0;
    logic [7:0] cmd1;
    logic [7:0] wdata;
    logic       busy, done, rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe;
    logic [7:0] rdata;
    logic       rtc_dat_i;
    logic       s_busy, s_done, s_cs_n, s_ck, s_dat_o, s_oe;
    logic [7:0] s_rdata;
    logic       s_dat_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_host #(.CLK_DIV(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .xcmd(xcmd),
        .cmd0(cmd0), .cmd1(cmd1), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .rtc_cs_n(rtc_cs_n), .rtc_ck(rtc_ck), .rtc_dat_o(rtc_dat_o),
        .rtc_dat_oe(rtc_dat_oe), .rtc_dat_i(rtc_dat_i)
    );

    rtc_host #(.CLK_DIV(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .xcmd(xcmd),
        .cmd0(cmd0), .cmd1(cmd1), .wdata(wdata),
        .busy(s_busy), .done(s_done), .rdata(s_rdata),
        .rtc_cs_n(s_cs_n), .rtc_ck(s_ck), .rtc_dat_o(s_dat_o),
        .rtc_dat_oe(s_oe), .rtc_dat_i(s_dat_i)
    );

    // Responder for the CLK_DIV=4 instance.
    int          mon_n      = 2;
    bit          mon_rd     = 1'b0;
    logic [7:0]  mon_rdbyte = 8'h00;
    int          mon_falls  = 0;
    int          mon_rises  = 0;
    logic [23:0] mon_cap    = '0;
    logic [23:0] mon_oe     = '0;
    int          done_count = 0;
    logic        prev_ck    = 1'b1;
    logic        prev_cs    = 1'b1;
    logic [7:0]  exp_rdata  = 8'h00;

    always @(negedge clk) begin
        int k;
        if (prev_cs && !rtc_cs_n) begin
            mon_falls = 0;
            mon_rises = 0;
            mon_cap   = '0;
            mon_oe    = '0;
        end
        if (!rtc_cs_n) begin
            if (prev_ck && !rtc_ck) begin
                if (mon_rd && mon_falls >= 8 * (mon_n - 1)) begin
                    k = mon_falls - 8 * (mon_n - 1);
                    rtc_dat_i = mon_rdbyte[7 - k];
                end
                mon_falls++;
            end
            if (!prev_ck && rtc_ck) begin
                mon_cap = {mon_cap[22:0], rtc_dat_o};
                mon_oe  = {mon_oe[22:0], rtc_dat_oe};
                mon_rises++;
            end
        end else begin
            rtc_dat_i = 1'b1;
        end
        prev_ck = rtc_ck;
        prev_cs = rtc_cs_n;
        if (done === 1'b1) done_count++;
    end

    // Responder for the CLK_DIV=16 instance (standard reads only).
    logic [7:0] rb16   = 8'h00;
    int         f16    = 0;
    logic       p16_ck = 1'b1;
    logic       p16_cs = 1'b1;

    always @(negedge clk) begin
        if (p16_cs && !s_cs_n) f16 = 0;
        if (!s_cs_n) begin
            if (p16_ck && !s_ck) begin
                if (f16 >= 8) s_dat_i = rb16[15 - f16];
                f16++;
            end
        end else begin
            s_dat_i = 1'b1;
        end
        p16_ck = s_ck;
        p16_cs = s_cs_n;
    end

    typedef struct {
        bit         x;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] wd;
        logic [7:0] rb;
    } txn_t;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe, busy, done, rdata} !== 14'b11_1000_0000_0000) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got cs_n=%b ck=%b dat_o=%b oe=%b busy=%b done=%b rdata=%h, required 1 1 1 0 0 0 00",
                     rtc_cs_n, rtc_ck, rtc_dat_o, rtc_dat_oe, busy, done, rdata);
        end
        n_cmp++;
        if ({s_cs_n, s_ck, s_dat_o, s_oe, s_busy, s_done, s_rdata} !== 14'b11_1000_0000_0000) begin
            n_bad++;
            $display("[TB] FAIL reset_state16: got cs_n=%b ck=%b oe=%b busy=%b rdata=%h", s_cs_n, s_ck, s_oe, s_busy, s_rdata);
        end
        reset = 1'b0;
        exp_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_transactions();
        txn_t q[$];
        txn_t tr;
        int t, n, k, exp_done;
        bit rd;
        logic [7:0] d;
        logic [23:0] exp_cap, exp_oe;
        q.push_back('{1'b0, 8'h35, 8'h00, 8'h00, 8'h00});
        q.push_back('{1'b0, 8'h41, 8'h00, 8'hA5, 8'h00});
        q.push_back('{1'b0, 8'hC1, 8'h00, 8'h00, 8'hA5});
        q.push_back('{1'b1, 8'h3A, 8'h1C, 8'h5A, 8'h00});
        q.push_back('{1'b1, 8'hBA, 8'h1C, 8'h00, 8'h5A});
        for (int i = 0; i < 10; i++) begin
            tr.x  = 1'($urandom_range(0, 1));
            tr.c0 = 8'($urandom);
            tr.c1 = 8'($urandom);
            tr.wd = 8'($urandom);
            tr.rb = 8'($urandom);
            q.push_back(tr);
        end
        foreach (q[i]) begin
            tr = q[i];
            rd = tr.c0[7];
            n  = tr.x ? 3 : 2;
            @(negedge clk);
            mon_n = n; mon_rd = rd; mon_rdbyte = tr.rb;
            xcmd = tr.x; cmd0 = tr.c0; cmd1 = tr.c1; wdata = tr.wd;
            start = 1'b1;
            t = cyc;
            @(negedge clk);
            start = 1'b0;
            xcmd = 1'($urandom); cmd0 = 8'($urandom); cmd1 = 8'($urandom); wdata = 8'($urandom);
            n_cmp++;
            if (busy !== 1'b1 || rtc_cs_n !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_begin: busy=%b cs_n=%b, required busy=1 cs_n=0", i, busy, rtc_cs_n);
            end
            k = 0;
            while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
            exp_done = t + 1 + (tr.x ? 51 : 35) * 4;
            n_cmp++;
            if (done !== 1'b1 || cyc != exp_done) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_done_cycle: done=%b at cycle %0d, required done=1 at %0d", i, done, cyc, exp_done);
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_busy_at_done: busy=%b, required 0", i, busy);
            end
            n_cmp++;
            if (mon_falls != 8 * n || mon_rises != 8 * n) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_edges: falls=%0d rises=%0d, required %0d", i, mon_falls, mon_rises, 8 * n);
            end
            d = rd ? 8'hFF : tr.wd;
            exp_cap = tr.x ? {tr.c0, tr.c1, d} : {8'h00, tr.c0, d};
            n_cmp++;
            if (mon_cap !== exp_cap) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_bits: sampled %h, required %h", i, mon_cap, exp_cap);
            end
            exp_oe = tr.x ? (rd ? 24'hFFFF00 : 24'hFFFFFF) : (rd ? 24'h00FF00 : 24'h00FFFF);
            n_cmp++;
            if (mon_oe !== exp_oe) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_oe: oe per bit %h, required %h", i, mon_oe, exp_oe);
            end
            if (rd) exp_rdata = tr.rb;
            n_cmp++;
            if (rdata !== exp_rdata) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_rdata: rdata=%h, required %h", i, rdata, exp_rdata);
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL txn%0d_done_width: done=%b one cycle later, required 0", i, done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int t, dc0;
        logic [7:0] c0, wd;
        c0 = 8'($urandom) & 8'h7F;
        wd = 8'($urandom);
        @(negedge clk);
        mon_n = 2; mon_rd = 1'b0;
        xcmd = 1'b0; cmd0 = c0; wdata = wd; start = 1'b1;
        t = cyc;
        dc0 = done_count;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            xcmd = 1'($urandom); cmd0 = 8'($urandom); cmd1 = 8'($urandom); wdata = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || cyc != t + 141) begin
            n_bad++;
            $display("[TB] FAIL busy_ignore_done: done=%b at cycle %0d, required done=1 at %0d", done, cyc, t + 141);
        end
        n_cmp++;
        if (mon_cap !== {8'h00, c0, wd} || mon_falls != 16) begin
            n_bad++;
            $display("[TB] FAIL busy_ignore_bits: sampled %h falls=%0d, required %h falls=16", mon_cap, mon_falls, {8'h00, c0, wd});
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (done_count - dc0 != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL busy_ignore_single: done pulses=%0d busy=%b, required 1 pulse busy=0", done_count - dc0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t, t2, k;
        logic [7:0] wd, rb;
        wd = 8'($urandom);
        rb = 8'($urandom);
        @(negedge clk);
        mon_n = 2; mon_rd = 1'b0;
        xcmd = 1'b0; cmd0 = 8'h41; wdata = wd; start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        n_cmp++;
        if (done !== 1'b1 || cyc != t + 141 || mon_cap[15:0] !== {8'h41, wd}) begin
            n_bad++;
            $display("[TB] FAIL b2b_first: done=%b cycle=%0d bits=%h, required done at %0d bits=%h", done, cyc, mon_cap[15:0], t + 141, {8'h41, wd});
        end
        mon_n = 2; mon_rd = 1'b1; mon_rdbyte = rb;
        cmd0 = 8'hC1; start = 1'b1;
        t2 = cyc;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (rtc_cs_n !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL b2b_restart: cs_n=%b busy=%b after done cycle, required 0 1", rtc_cs_n, busy);
        end
        k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        exp_rdata = rb;
        n_cmp++;
        if (done !== 1'b1 || cyc != t2 + 141 || rdata !== rb) begin
            n_bad++;
            $display("[TB] FAIL b2b_second: done=%b cycle=%0d rdata=%h, required done at %0d rdata=%h", done, cyc, rdata, t2 + 141, rb);
        end
    endtask

    task automatic test_reset_mid();
        int t, dc0, k;
        logic [7:0] rb;
        @(negedge clk);
        mon_n = 2; mon_rd = 1'b0;
        xcmd = 1'b0; cmd0 = 8'h41; wdata = 8'($urandom); start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 60) @(negedge clk);
        reset = 1'b1;
        dc0 = done_count;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 8'h00;
        n_cmp++;
        if ({rtc_cs_n, rtc_ck, rtc_dat_oe, busy, done} !== 5'b11000) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_outputs: cs_n=%b ck=%b oe=%b busy=%b done=%b at t+%0d, required 1 1 0 0 0",
                     rtc_cs_n, rtc_ck, rtc_dat_oe, busy, done, cyc - t);
        end
        repeat (250) @(negedge clk);
        n_cmp++;
        if (done_count != dc0 || busy !== 1'b0 || rdata !== 8'h00) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_no_done: done pulses=%0d busy=%b rdata=%h, required 0 0 00", done_count - dc0, busy, rdata);
        end
        rb = 8'($urandom);
        mon_n = 2; mon_rd = 1'b1; mon_rdbyte = rb;
        cmd0 = 8'hC1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        exp_rdata = rb;
        n_cmp++;
        if (done !== 1'b1 || rdata !== rb) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_recover: done=%b rdata=%h, required done=1 rdata=%h", done, rdata, rb);
        end
    endtask

    task automatic test_clkdiv16();
        int t, k;
        for (int i = 0; i < 2; i++) begin
            rb16 = (i == 0) ? 8'h05 : 8'($urandom);
            @(negedge clk);
            xcmd = 1'b0; cmd0 = 8'h81; start16 = 1'b1;
            t = cyc;
            @(negedge clk);
            start16 = 1'b0;
            k = 0;
            while (s_done !== 1'b1 && k < 1200) begin @(negedge clk); k++; end
            n_cmp++;
            if (s_done !== 1'b1 || cyc != t + 561) begin
                n_bad++;
                $display("[TB] FAIL div16_done_cycle%0d: done=%b at cycle %0d, required %0d", i, s_done, cyc, t + 561);
            end
            n_cmp++;
            if (s_rdata !== rb16) begin
                n_bad++;
                $display("[TB] FAIL div16_rdata%0d: rdata=%h, required %h", i, s_rdata, rb16);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; start16 = 1'b0;
        xcmd = 1'b0; cmd0 = 8'h00; cmd1 = 8'h00; wdata = 8'h00;
        rtc_dat_i = 1'b1; s_dat_i = 1'b1;
        test_reset();
        test_transactions();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_clkdiv16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_host.md
# rtc_host

Serial initiator for the 3-wire PRAM/RTC bus (chip select, clock, bidirectional data). It converts a parallel request into one complete bus transaction and returns the read byte. A transaction is a standard command (command byte plus data byte) or an extended XPRAM command (two command bytes plus data byte). It sits between the IO controller/host-register side and the `rtc` responder, and also serves as the bus driver in responder testbenches.

## Interface
- `CLK_DIV`, default 8: clk cycles per half period of `rtc_ck`; legal range 4..255.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only while `busy`=0.
- `xcmd`  in  1  1 = extended (two command bytes), 0 = standard.
- `cmd0`  in  8  first command byte; bit 7 = 1 means read.
- `cmd1`  in  8  second command byte, used only when `xcmd`=1.
- `wdata`  in  8  data byte for writes.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  8  byte read; valid from `done` until the next `done`.
- `rtc_cs_n`  out  1  chip select, active low.
- `rtc_ck`  out  1  serial clock, idles high.
- `rtc_dat_o`  out  1  serial data to the responder.
- `rtc_dat_oe`  out  1  1 = host drives data.
- `rtc_dat_i`  in  1  serial data from the responder.

## Operation
- Reset values: `rtc_cs_n`=1, `rtc_ck`=1, `rtc_dat_o`=1, `rtc_dat_oe`=0, `busy`=0, `done`=0, `rdata`=0x00.
- A start accepted in IDLE latches `xcmd`, `cmd0`, `cmd1` and `wdata`. Input changes after acceptance are ignored.
- Byte count N: 2 when `xcmd`=0, 3 when `xcmd`=1. The last byte is the data byte; all others are command bytes. Direction is given by the latched `cmd0[7]`.
- State sequence: IDLE -> SETUP -> (LOW, HIGH) x 8N -> HOLD -> GAP -> IDLE. Each state except IDLE lasts CLK_DIV cycles.
- IDLE: `rtc_cs_n`=1, `rtc_ck`=1, `rtc_dat_oe`=0.
- SETUP: `rtc_cs_n`=0, `rtc_ck`=1.
- LOW and HIGH:
  - `rtc_ck`=0 in LOW, 1 in HIGH.
  - Bits go MSB first.
  - Command bytes, and the data byte of a write: `rtc_dat_oe`=1. `rtc_dat_o` takes the next bit on the first LOW cycle and holds it through HIGH.
  - Read data byte: `rtc_dat_oe`=0 and `rtc_dat_o`=1 for all 16 of its LOW/HIGH phases. `rtc_dat_i` is shifted in on the last cycle of each LOW, immediately before the rising edge.
- HOLD: `rtc_ck`=1, `rtc_cs_n`=0, `rtc_dat_oe`=0.
- GAP: `rtc_cs_n`=1.
- On GAP exit: `done`=1 for one cycle, and `busy`=0 in that same cycle. On a read, `rdata` is loaded with the shifted byte in that cycle. On a write, `rdata` is unchanged.
- `start` sampled in the `done` cycle is accepted, so transactions can run back-to-back.
- `start` while `busy`=1 is ignored. There is no queueing.
- Reset mid-transaction: the next cycle shows reset values, and no `done` is produced. The responder resynchronises on `rtc_cs_n` high.

## Timing
- Bit period is 2·CLK_DIV cycles. The responder samples on the `rtc_ck` rising edge and drives on the falling edge.
- CLK_DIV ≥ 4 is required. This covers the responder's 3-cycle RAM read path after the last command bit and its 1-cycle output register after a falling edge.
- Start sampled in cycle t:
  - `busy` goes to 1 and `rtc_cs_n` to 0 in cycle t+1.
  - Standard: `done` in cycle t+1+35·CLK_DIV.
  - Extended: `done` in cycle t+1+51·CLK_DIV.
- First falling edge of `rtc_ck` is at t+1+CLK_DIV.
- Last rising edge is at t+1+(1+16N)·CLK_DIV−CLK_DIV, i.e. the start of the final HIGH.
- `rtc_cs_n` rises at t+1+(2+16N)·CLK_DIV.
- All outputs are registered, with no combinational path from inputs to outputs.
- `rtc_dat_i` is used directly: the responder is synchronous to `clk`. An asynchronous top-level must add a 2-flop synchroniser and increase CLK_DIV accordingly.

## Test plan
All scenarios use CLK_DIV=4 with the `rtc` responder attached (xpram=1) unless noted.
- Standard write, `cmd0`=0x35, `wdata`=0x00 -> exactly 16 falling edges; bits sampled on rising edges are 0x35 then 0x00; `done` at t+141; responder write-protect clears.
- Write `cmd0`=0x41, `wdata`=0xA5, then read `cmd0`=0xC1 -> `rdata`=0xA5 (PRAM 0x10). `rtc_dat_oe`=0 exactly during the read's data byte.
- Extended write `cmd0`=0x3A, `cmd1`=0x1C, `wdata`=0x5A, then extended read `cmd0`=0xBA, `cmd1`=0x1C -> `rdata`=0x5A (XPRAM 0x47); `done` at t+205; 24 clock pulses.
- `start` pulsed every cycle during a transaction -> exactly one transaction runs. `start` asserted in the `done` cycle -> next `rtc_cs_n` fall on the following cycle.
- `reset` asserted in cycle t+60 of a write -> cycle t+61 shows `rtc_cs_n`=1, `rtc_ck`=1, `rtc_dat_oe`=0, `busy`=0, and no `done`. A subsequent read of `cmd0`=0xC1 returns the pre-existing PRAM value.
- Clock read `cmd0`=0x81 with rtc=00:00:05 on 1904-01-01 -> `rdata`=0x05; repeat with CLK_DIV=16 -> same data, `done` at t+561.
